// File: rtl/block_ram_load_ctrl.sv
// Weight-RAM load/read controller: scatters a word stream into RAM rows and gates consumer reads.
// Optional abort input enabled by defining BLOCK_RAM_LOAD_CTRL_ABORT_EN.
module block_ram_load_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 128,
  parameter int NUM_WORDS  = 288
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [DATA_WIDTH-1:0]    in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
`ifdef BLOCK_RAM_LOAD_CTRL_ABORT_EN
  input  logic                     abort,
`endif
  output logic [DATA_WIDTH-1:0]    ram_wr_data,
  output logic [$clog2(DEPTH)-1:0] ram_wr_addr,
  output logic [NUM_WORDS-1:0]     ram_wr_en,
  output logic                     busy,
  output logic                     done,
  output logic                     loaded,
  input  logic                     rd_req,
  input  logic [$clog2(DEPTH)-1:0] rd_req_addr,
  output logic                     ram_rd_en,
  output logic [$clog2(DEPTH)-1:0] ram_rd_addr,
  output logic                     rd_valid
);

  localparam int AW = $clog2(DEPTH);
  localparam int WW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t               state_reg, state_next;
  logic [WW-1:0]        word_cnt_reg;
  logic [AW-1:0]        row_cnt_reg;
  logic                 loaded_reg;
  logic                 rd_valid_reg;
  logic                 accept;
  logic                 last_word;
  logic                 last_row;
  logic                 abort_hit;
  logic [NUM_WORDS-1:0] word_sel;

`ifdef BLOCK_RAM_LOAD_CTRL_ABORT_EN
  assign abort_hit = abort & (state_reg != IDLE);
`else
  assign abort_hit = 1'b0;
`endif

  assign accept    = in_valid & in_ready;
  assign last_word = (word_cnt_reg == WW'(NUM_WORDS - 1));
  assign last_row  = (row_cnt_reg == AW'(DEPTH - 1));

  genvar gi;
  generate
    for (gi = 0; gi < NUM_WORDS; gi++) begin : g_word_sel
      assign word_sel[gi] = (word_cnt_reg == WW'(gi));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = LOAD;
      LOAD: begin
        if (abort_hit)                          state_next = IDLE;
        else if (accept && last_word && last_row) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state_reg == LOAD);
    busy     = (state_reg != IDLE);
    done     = (state_reg == DONE) & ~abort_hit;
  end

  // Abort takes priority over counting; a word accepted alongside abort is still written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_cnt_reg <= '0;
      row_cnt_reg  <= '0;
      loaded_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            word_cnt_reg <= '0;
            row_cnt_reg  <= '0;
            loaded_reg   <= 1'b0;
          end
        end
        LOAD: begin
          if (abort_hit) begin
            word_cnt_reg <= '0;
            row_cnt_reg  <= '0;
          end else if (accept) begin
            if (last_word) begin
              word_cnt_reg <= '0;
              row_cnt_reg  <= last_row ? '0 : row_cnt_reg + 1'b1;
            end else begin
              word_cnt_reg <= word_cnt_reg + 1'b1;
            end
          end
        end
        DONE: begin
          word_cnt_reg <= '0;
          row_cnt_reg  <= '0;
          if (!abort_hit) loaded_reg <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_wr_en   <= '0;
      ram_wr_data <= '0;
      ram_wr_addr <= '0;
    end else begin
      ram_wr_en <= accept ? word_sel : '0;
      if (accept) begin
        ram_wr_data <= in_data;
        ram_wr_addr <= row_cnt_reg;
      end
    end
  end

  assign ram_rd_en   = rd_req & loaded_reg & ~busy;
  assign ram_rd_addr = rd_req_addr;
  assign loaded      = loaded_reg;
  assign rd_valid    = rd_valid_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_valid_reg <= 1'b0;
    else        rd_valid_reg <= ram_rd_en;
  end

endmodule
